// File: rtl/spi_reg_ctrl.sv
// Register-bank access controller for the SPI slave path: config writes, read fetches, pointer auto-increment, and an illegal-access counter.
// Optional feature: define SPI_REG_WRITE_LOCK_EN so that bit0 of address RO_BASE-1 write-protects the other config registers.
module spi_reg_ctrl #(
    parameter int RO_BASE = 7'h60
) (
    input  logic                        spi_clk,
    input  logic                        rstn,
    input  logic                        cmd_valid,
    input  logic                        is_write,
    input  logic [6:0]                  addr,
    input  logic                        data_valid,
    input  logic [7:0]                  wdata,
    input  logic [(128-RO_BASE)*8-1:0]  status_flat,
    output logic [RO_BASE*8-1:0]        cfg_flat,
    output logic [7:0]                  tx_byte,
    output logic                        tx_load,
    output logic [7:0]                  err_cnt
);

    localparam logic [6:0] RO_BASE_A = 7'(RO_BASE);
    localparam logic [6:0] LOCK_A    = 7'(RO_BASE - 1);
    localparam int         LOCK_IDX  = RO_BASE - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [6:0] ptr_q, ptr_d;
    logic [7:0] cfg_q [RO_BASE];
    logic [7:0] cfg_d [RO_BASE];
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       tx_load_q, tx_load_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic [7:0] rd_map_s [128];
    logic       wr_ok_s;
    logic       wr_en_s;
    logic       err_inc_s;

    // Full 128-byte read map: config below RO_BASE, live status inputs above.
    for (genvar g = 0; g < 128; g++) begin : g_map
        if (g < RO_BASE) begin : g_cfg
            assign rd_map_s[g] = cfg_q[g];
        end else begin : g_stat
            assign rd_map_s[g] = status_flat[(g-RO_BASE)*8 +: 8];
        end
    end

    for (genvar g = 0; g < RO_BASE; g++) begin : g_flat
        assign cfg_flat[g*8 +: 8] = cfg_q[g];
    end

`ifdef SPI_REG_WRITE_LOCK_EN
    // The lock register stays writable so a locked bank can always be unlocked.
    assign wr_ok_s = (ptr_q < RO_BASE_A) && (!cfg_q[LOCK_IDX][0] || (ptr_q == LOCK_A));
`else
    assign wr_ok_s = (ptr_q < RO_BASE_A);
`endif

    // Next-state: command decode has priority, then burst continuation per state.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        tx_byte_d = tx_byte_q;
        tx_load_d = 1'b0;
        wr_en_s   = 1'b0;
        err_inc_s = 1'b0;
        if (cmd_valid) begin
            ptr_d = addr;
            if (is_write) begin
                state_d = ST_WRITE;
            end else begin
                state_d   = ST_READ;
                tx_byte_d = rd_map_s[addr];
                tx_load_d = 1'b1;
                ptr_d     = addr + 7'd1;
            end
        end else if (data_valid) begin
            case (state_q)
                ST_IDLE: begin
                    err_inc_s = 1'b1;
                end
                ST_WRITE: begin
                    if (wr_ok_s) begin
                        wr_en_s = 1'b1;
                    end else begin
                        err_inc_s = 1'b1;
                    end
                    ptr_d = ptr_q + 7'd1;
                end
                ST_READ: begin
                    tx_byte_d = rd_map_s[ptr_q];
                    tx_load_d = 1'b1;
                    ptr_d     = ptr_q + 7'd1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (err_inc_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end

        for (int i = 0; i < RO_BASE; i++) begin
            if (wr_en_s && (ptr_q == 7'(i))) begin
                cfg_d[i] = wdata;
            end else begin
                cfg_d[i] = cfg_q[i];
            end
        end
    end

    // State, pointer, config bank and registered outputs.
    always_ff @(posedge spi_clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 7'd0;
            tx_byte_q <= 8'h00;
            tx_load_q <= 1'b0;
            err_cnt_q <= 8'h00;
            for (int i = 0; i < RO_BASE; i++) begin
                cfg_q[i] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            tx_byte_q <= tx_byte_d;
            tx_load_q <= tx_load_d;
            err_cnt_q <= err_cnt_d;
            cfg_q     <= cfg_d;
        end
    end

    assign tx_byte = tx_byte_q;
    assign tx_load = tx_load_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed scenarios plus a randomized run against a byte-level reference model.
module tb_spi_reg_ctrl;

    localparam int RO = 96;

    logic                  spi_clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  cmd_valid = 1'b0;
    logic                  is_write = 1'b0;
    logic [6:0]            addr = 7'd0;
    logic                  data_valid = 1'b0;
    logic [7:0]            wdata = 8'h00;
    logic [(128-RO)*8-1:0] status_flat = '0;
    logic [RO*8-1:0]       cfg_flat;
    logic [7:0]            tx_byte;
    logic                  tx_load;
    logic [7:0]            err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int         m_state;
    int         m_ptr;
    int         m_err;
    logic [7:0] m_cfg [RO];
    logic [7:0] m_tx;
    logic       m_load;

    spi_reg_ctrl #(.RO_BASE(RO)) dut (
        .spi_clk(spi_clk), .rstn(rstn), .cmd_valid(cmd_valid), .is_write(is_write),
        .addr(addr), .data_valid(data_valid), .wdata(wdata), .status_flat(status_flat),
        .cfg_flat(cfg_flat), .tx_byte(tx_byte), .tx_load(tx_load), .err_cnt(err_cnt)
    );

    always #5 spi_clk = ~spi_clk;

    function automatic logic [7:0] cfg_at(input int i);
        return cfg_flat[i*8 +: 8];
    endfunction

    task automatic drive(input logic c, input logic w, input logic [6:0] a,
                         input logic d, input logic [7:0] wd);
        cmd_valid  = c;
        is_write   = w;
        addr       = a;
        data_valid = d;
        wdata      = wd;
        @(posedge spi_clk);
        #1;
        cmd_valid  = 1'b0;
        data_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge spi_clk);
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        @(posedge spi_clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (cfg_flat !== '0) begin n_bad++; $display("FAIL reset_cfg: got %h expected 0", cfg_flat); end
        n_cmp++; if (tx_byte !== 8'h00) begin n_bad++; $display("FAIL reset_tx_byte: got %h expected 00", tx_byte); end
        n_cmp++; if (tx_load !== 1'b0) begin n_bad++; $display("FAIL reset_tx_load: got %b expected 0", tx_load); end
        n_cmp++; if (err_cnt !== 8'h00) begin n_bad++; $display("FAIL reset_err: got %h expected 00", err_cnt); end
    endtask

    task automatic test_write_burst();
        drive(1'b1, 1'b1, 7'h10, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 7'h00, 1'b1, 8'hA5);
        n_cmp++; if (cfg_at(16) !== 8'hA5) begin n_bad++; $display("FAIL wr_latency: got %h expected a5", cfg_at(16)); end
        drive(1'b0, 1'b0, 7'h00, 1'b1, 8'h3C);
        n_cmp++; if (cfg_at(17) !== 8'h3C) begin n_bad++; $display("FAIL wr_burst_11: got %h expected 3c", cfg_at(17)); end
        n_cmp++; if (cfg_at(16) !== 8'hA5) begin n_bad++; $display("FAIL wr_burst_10: got %h expected a5", cfg_at(16)); end
        n_cmp++; if (err_cnt !== 8'h00) begin n_bad++; $display("FAIL wr_burst_err: got %h expected 00", err_cnt); end
    endtask

    task automatic test_read_burst();
        status_flat[7:0] = 8'h5A;
        drive(1'b1, 1'b1, 7'h5F, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 7'h00, 1'b1, 8'hC2);
        drive(1'b1, 1'b0, 7'h5F, 1'b0, 8'h00);
        n_cmp++; if (tx_load !== 1'b1) begin n_bad++; $display("FAIL rd_load1: got %b expected 1", tx_load); end
        n_cmp++; if (tx_byte !== 8'hC2) begin n_bad++; $display("FAIL rd_byte_cfg: got %h expected c2", tx_byte); end
        drive(1'b0, 1'b0, 7'h00, 1'b0, 8'h00);
        n_cmp++; if (tx_load !== 1'b0) begin n_bad++; $display("FAIL rd_load_low: got %b expected 0", tx_load); end
        drive(1'b0, 1'b0, 7'h00, 1'b1, 8'h00);
        n_cmp++; if (tx_load !== 1'b1) begin n_bad++; $display("FAIL rd_load2: got %b expected 1", tx_load); end
        n_cmp++; if (tx_byte !== 8'h5A) begin n_bad++; $display("FAIL rd_byte_stat: got %h expected 5a", tx_byte); end
    endtask

    task automatic test_back_to_back();
        status_flat[23:0] = 24'h33_22_11;
        drive(1'b1, 1'b0, 7'h60, 1'b0, 8'h00);
        n_cmp++; if ({tx_load, tx_byte} !== {1'b1, 8'h11}) begin n_bad++; $display("FAIL b2b_0: got %b/%h expected 1/11", tx_load, tx_byte); end
        drive(1'b0, 1'b0, 7'h00, 1'b1, 8'h00);
        n_cmp++; if ({tx_load, tx_byte} !== {1'b1, 8'h22}) begin n_bad++; $display("FAIL b2b_1: got %b/%h expected 1/22", tx_load, tx_byte); end
        drive(1'b0, 1'b0, 7'h00, 1'b1, 8'h00);
        n_cmp++; if ({tx_load, tx_byte} !== {1'b1, 8'h33}) begin n_bad++; $display("FAIL b2b_2: got %b/%h expected 1/33", tx_load, tx_byte); end
    endtask

    task automatic test_wrap_ro();
        do_reset();
        drive(1'b1, 1'b1, 7'h7F, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 7'h00, 1'b1, 8'h11);
        drive(1'b0, 1'b0, 7'h00, 1'b1, 8'h22);
        n_cmp++; if (err_cnt !== 8'h01) begin n_bad++; $display("FAIL wrap_err: got %h expected 01", err_cnt); end
        n_cmp++; if (cfg_at(0) !== 8'h22) begin n_bad++; $display("FAIL wrap_cfg0: got %h expected 22", cfg_at(0)); end
    endtask

    task automatic test_collision_idle();
        do_reset();
        drive(1'b0, 1'b0, 7'h00, 1'b1, 8'h44);
        n_cmp++; if (err_cnt !== 8'h01) begin n_bad++; $display("FAIL idle_err: got %h expected 01", err_cnt); end
        drive(1'b1, 1'b1, 7'h05, 1'b1, 8'h99);
        n_cmp++; if (cfg_at(5) !== 8'h00) begin n_bad++; $display("FAIL coll_nowrite: got %h expected 00", cfg_at(5)); end
        n_cmp++; if (err_cnt !== 8'h01) begin n_bad++; $display("FAIL coll_err: got %h expected 01", err_cnt); end
        drive(1'b0, 1'b0, 7'h00, 1'b1, 8'h77);
        n_cmp++; if (cfg_at(5) !== 8'h77) begin n_bad++; $display("FAIL coll_next: got %h expected 77", cfg_at(5)); end
    endtask

    task automatic test_lock();
        do_reset();
        drive(1'b1, 1'b1, 7'h5F, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 7'h00, 1'b1, 8'h01);
        drive(1'b1, 1'b1, 7'h02, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 7'h00, 1'b1, 8'hFF);
`ifdef SPI_REG_WRITE_LOCK_EN
        n_cmp++; if (cfg_at(2) !== 8'h00) begin n_bad++; $display("FAIL lock_block: got %h expected 00", cfg_at(2)); end
        n_cmp++; if (err_cnt !== 8'h01) begin n_bad++; $display("FAIL lock_err: got %h expected 01", err_cnt); end
        drive(1'b1, 1'b1, 7'h5F, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 7'h00, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 7'h02, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 7'h00, 1'b1, 8'hFF);
        n_cmp++; if (cfg_at(2) !== 8'hFF) begin n_bad++; $display("FAIL unlock_write: got %h expected ff", cfg_at(2)); end
        n_cmp++; if (err_cnt !== 8'h01) begin n_bad++; $display("FAIL unlock_err: got %h expected 01", err_cnt); end
`else
        n_cmp++; if (cfg_at(2) !== 8'hFF) begin n_bad++; $display("FAIL nolock_write: got %h expected ff", cfg_at(2)); end
        n_cmp++; if (cfg_at(95) !== 8'h01) begin n_bad++; $display("FAIL nolock_reg: got %h expected 01", cfg_at(95)); end
        n_cmp++; if (err_cnt !== 8'h00) begin n_bad++; $display("FAIL nolock_err: got %h expected 00", err_cnt); end
`endif
    endtask

    function automatic logic [7:0] m_rd(input int a);
        if (a < RO) return m_cfg[a];
        return status_flat[(a-RO)*8 +: 8];
    endfunction

    task automatic test_random();
        logic [RO*8-1:0] exp_flat;
        logic       c, w, d;
        logic [6:0] a;
        logic [7:0] wd;
        bit         ok;
        do_reset();
        m_state = 0; m_ptr = 0; m_err = 0; m_tx = 8'h00;
        for (int i = 0; i < RO; i++) m_cfg[i] = 8'h00;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < 8; k++) status_flat[k*32 +: 32] = $urandom;
            end
            c  = ($urandom_range(0, 5) == 0);
            d  = ($urandom_range(0, 2) != 0);
            w  = $urandom_range(0, 1);
            wd = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       a = 7'($urandom_range(94, 97));
                1:       a = 7'($urandom_range(125, 127));
                default: a = 7'($urandom_range(0, 127));
            endcase
            m_load = 1'b0;
            if (c) begin
                m_ptr = a;
                if (w) m_state = 1;
                else begin
                    m_state = 2; m_tx = m_rd(a); m_load = 1'b1; m_ptr = (a + 1) % 128;
                end
            end else if (d) begin
                if (m_state == 0) begin
                    if (m_err < 255) m_err++;
                end else if (m_state == 1) begin
`ifdef SPI_REG_WRITE_LOCK_EN
                    ok = (m_ptr < RO) && (m_cfg[RO-1][0] == 1'b0 || m_ptr == RO-1);
`else
                    ok = (m_ptr < RO);
`endif
                    if (ok) m_cfg[m_ptr] = wd;
                    else if (m_err < 255) m_err++;
                    m_ptr = (m_ptr + 1) % 128;
                end else begin
                    m_tx = m_rd(m_ptr); m_load = 1'b1; m_ptr = (m_ptr + 1) % 128;
                end
            end
            drive(c, w, a, d, wd);
            for (int i = 0; i < RO; i++) exp_flat[i*8 +: 8] = m_cfg[i];
            n_cmp++; if (cfg_flat !== exp_flat) begin n_bad++; $display("FAIL rnd_cfg[%0d]: got %h expected %h", n, cfg_flat[127:0], exp_flat[127:0]); end
            n_cmp++; if (err_cnt !== 8'(m_err)) begin n_bad++; $display("FAIL rnd_err[%0d]: got %h expected %h", n, err_cnt, 8'(m_err)); end
            n_cmp++; if (tx_load !== m_load) begin n_bad++; $display("FAIL rnd_load[%0d]: got %b expected %b", n, tx_load, m_load); end
            n_cmp++; if (tx_byte !== m_tx) begin n_bad++; $display("FAIL rnd_tx[%0d]: got %h expected %h", n, tx_byte, m_tx); end
        end
    endtask

    task automatic test_saturation_reset();
        do_reset();
        for (int n = 0; n < 300; n++) drive(1'b0, 1'b0, 7'h00, 1'b1, 8'h00);
        n_cmp++; if (err_cnt !== 8'hFF) begin n_bad++; $display("FAIL sat_err: got %h expected ff", err_cnt); end
        drive(1'b1, 1'b1, 7'h03, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 7'h00, 1'b1, 8'hAB);
        n_cmp++; if (cfg_at(3) !== 8'hAB) begin n_bad++; $display("FAIL sat_write: got %h expected ab", cfg_at(3)); end
        drive(1'b1, 1'b0, 7'h03, 1'b0, 8'h00);
        rstn = 1'b0;
        #1;
        n_cmp++; if ({cfg_flat, tx_byte, tx_load, err_cnt} !== '0) begin n_bad++; $display("FAIL async_rst: got cfg3=%h tx=%h ld=%b err=%h expected all 0", cfg_at(3), tx_byte, tx_load, err_cnt); end
        #2;
        rstn = 1'b1;
        @(posedge spi_clk);
        #1;
        drive(1'b0, 1'b0, 7'h00, 1'b1, 8'h55);
        n_cmp++; if (err_cnt !== 8'h01) begin n_bad++; $display("FAIL rst_idle_err: got %h expected 01", err_cnt); end
        n_cmp++; if (cfg_flat !== '0) begin n_bad++; $display("FAIL rst_idle_cfg: got %h expected 0", cfg_flat); end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_back_to_back();
        test_wrap_ro();
        test_collision_idle();
        test_lock();
        test_random();
        test_saturation_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
